kmp_pe: RTL and testbench
=========================

# kmp_pe

Single KMP processing element (PE) for the parallel string-matching engine. It is the responder to the KMP control unit. The control unit issues `pe_valid` with a string window (`start_idx`, `end_idx`). The PE builds the failure table for the broadcast pattern, scans its window of the shared string buffer, and returns `match_valid`, `match` and `match_idx`. Four instances sit side by side. Their outputs feed the control unit's min-index reduction.

## Interface
- `STR_ADDR_W`, default 6: string address width; equals the control unit's `MAX_STR_ADD`.
- `PAT_ADDR_W`, default 3: pattern address width.
- `MAX_PAT`, default 8: pattern storage depth; `2**PAT_ADDR_W`.
- `CHAR_W`, default 8: character width.
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `pat_we`, in, 1: pattern broadcast write strobe.
- `pat_waddr`, in, `PAT_ADDR_W`: pattern write index.
- `pat_wdata`, in, `CHAR_W`: pattern character.
- `pat_last_idx`, in, `PAT_ADDR_W`: index of last pattern character (pattern length − 1).
- `pe_valid`, in, 1: level request from the control unit; held high for the whole job.
- `start_idx`, in, `STR_ADDR_W`: first string index of the window.
- `end_idx`, in, `STR_ADDR_W`: last string index of the window (control unit's `process_2idx`).
- `str_raddr`, out, `STR_ADDR_W`: string buffer read address.
- `str_rdata`, in, `CHAR_W`: string character; a combinational function of `str_raddr`.
- `match_valid`, out, 1: result valid; held high while `pe_valid` stays high.
- `match`, out, 1: pattern found in the window.
- `match_idx`, out, `STR_ADDR_W`: string index of the first character of the first match; 0 when `match`=0.

## Operation
- Pattern storage is `MAX_PAT` × `CHAR_W` registers.
  - A `pat_we` write is accepted only in IDLE; in other states it is ignored.
  - Contents are not cleared by reset.
- Failure table `fail[0..MAX_PAT-1]` has width `PAT_ADDR_W`; it is rebuilt for every job.
- States are IDLE, BUILD, SCAN and DONE.
- **IDLE:**
  - `pe_valid`=1 latches `start_idx`, `end_idx` and `pat_last_idx`.
  - It sets `k`=1, `len`=0 and `fail[0]`=0, then goes to BUILD.
- **BUILD** takes one step per cycle:
  - If `k` > `pat_last`: go to SCAN with `i`=start and `j`=0.
  - Else if `p[k]`==`p[len]`: set `fail[k]`=`len`+1, `len`++, `k`++.
  - Else if `len`≠0: set `len`=`fail[len-1]`.
  - Else: set `fail[k]`=0 and `k`++.
- **SCAN** takes one step per cycle, with `str_raddr`=`i`:
  - If `i` > end, or `i` overflows: go to DONE with `match`=0 and `match_idx`=0.
  - Else if `str_rdata`==`p[j]` and `j`==`pat_last`: go to DONE with `match`=1 and `match_idx`=`i`−`pat_last`.
  - Else if `str_rdata`==`p[j]`: `i`++, `j`++.
  - Else if `j`≠0: set `j`=`fail[j-1]`; `i` holds.
  - Else: `i`++.
- **DONE:** `match_valid`=1, and results are held stable.
  - When `pe_valid` drops, go to IDLE; `match_valid`, `match` and `match_idx` clear.
- `pe_valid` low in BUILD or SCAN aborts the job: next state is IDLE and outputs are 0.
- A window with start > end ends with `match`=0.
- A pattern longer than the window ends with `match`=0.
- `i` is `STR_ADDR_W`+1 bits internally so that end = max index terminates cleanly.
- All comparisons are unsigned.

## Timing
- Reset values:
  - state IDLE;
  - `match_valid`, `match`, `match_idx` and `str_raddr` all 0.
- The BUILD step count is ≤ 2·`pat_last_idx`+1 cycles.
  - The cycle in which `k` > `pat_last_idx` is detected counts.
  - With `pat_last_idx`=0, BUILD lasts exactly 1 cycle.
- The SCAN step count is ≤ 2·(end−start+1)+1 cycles.
- `match_valid` rises on the clock edge that enters DONE.
- Drop timing:
  - `pe_valid` low sampled at edge N puts the PE in IDLE after N.
  - After N, `match_valid` is 0.
  - A new job may start at edge N+1.
- Simultaneous `pat_we` and `pe_valid` in IDLE: the write completes and the job starts.
  - BUILD uses the updated pattern starting the next cycle.
- `reset` overrides everything at any state.

## Configuration
- `KMP_PE_CYCLE_CNT_EN` defined:
  - Adds output `job_cycles` (16 bits).
  - It is cleared on IDLE→BUILD, increments each BUILD/SCAN cycle, saturates at 0xFFFF, and is held in DONE.
  - Reset value is 0.
- `KMP_PE_CYCLE_CNT_EN` undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- The shared package `sme_pkg` holds:
  - width constants (`STR_ADDR_W`, `PAT_ADDR_W`, `CHAR_W`);
  - the 2-bit state encoding (IDLE=0, BUILD=1, SCAN=2, DONE=3).
- Sub-module `kmp_fail_builder` contains the BUILD loop and the failure table registers.
  - Its ports are `start`, `pat` flat vector, `pat_last`, `done`, and a `fail` read port.
  - The SCAN FSM stays in `kmp_pe`.

## Test plan
- String "ABABCABAB", pattern "ABC" (`pat_last_idx`=2), window 0..5 → `match`=1, `match_idx`=2, `match_valid` held until `pe_valid` drops.
- String "AAAAB", pattern "AAB", window 0..4 → `fail`={0,1,0}; the fallback path is exercised; `match`=1, `match_idx`=2.
- String "ABABCABAB", pattern "CC", window 0..8 → `match`=0, `match_idx`=0; also window start=5, end=3 → `match`=0.
- Pattern "B" (`pat_last_idx`=0), window 2..8 of "ABABCABAB" → BUILD lasts 1 cycle; `match_idx`=3.
- `pe_valid` dropped during SCAN → IDLE next edge, outputs 0; a restarted job gives the correct result. Assert `reset` during BUILD → all outputs 0, state IDLE.
- `pat_we` pulsed during SCAN → pattern unchanged; the result equals the result without the write.

Source files
------------

// File: rtl/sme_pkg.sv
`default_nettype none
// ============================================================
// Package : sme_pkg
// Desc    : Shared widths and PE state encoding for the string-matching engine.
// Rev     : 1.0
// ============================================================
package sme_pkg;

  localparam int STR_ADDR_W = 6;
  localparam int PAT_ADDR_W = 3;
  localparam int CHAR_W     = 8;
  localparam int MAX_PAT    = 2 ** PAT_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUILD = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } pe_state_t;

endpackage
`default_nettype wire

// File: rtl/kmp_fail_builder.sv
`default_nettype none
// ============================================================
// Module  : kmp_fail_builder
// Desc    : KMP failure-table construction loop, one step per cycle.
// Rev     : 1.0
// ============================================================
module kmp_fail_builder
  import sme_pkg::*;
#(
  parameter int PAT_ADDR_W = sme_pkg::PAT_ADDR_W,
  parameter int CHAR_W     = sme_pkg::CHAR_W,
  parameter int MAX_PAT    = 2 ** PAT_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MAX_PAT*CHAR_W-1:0] pat,
  input  logic [PAT_ADDR_W-1:0]     pat_last,
  output logic                      done,
  input  logic [PAT_ADDR_W-1:0]     fail_raddr,
  output logic [PAT_ADDR_W-1:0]     fail_rdata
);

  localparam logic [PAT_ADDR_W:0]   c_one_k   = 1;
  localparam logic [PAT_ADDR_W-1:0] c_one_len = 1;

  logic                  r_busy;
  logic [PAT_ADDR_W:0]   r_k;
  logic [PAT_ADDR_W-1:0] r_len;
  logic [PAT_ADDR_W-1:0] r_fail [MAX_PAT];
  logic [CHAR_W-1:0]     w_pat  [MAX_PAT];
  logic [PAT_ADDR_W-1:0] w_kidx;
  logic                  w_step;

  for (genvar g = 0; g < MAX_PAT; g++) begin : g_unpack
    assign w_pat[g] = pat[g*CHAR_W +: CHAR_W];
  end

  // k carries one extra bit so that k > pat_last is reachable at full depth
  assign w_kidx     = r_k[PAT_ADDR_W-1:0];
  assign done       = r_busy && (r_k > {1'b0, pat_last});
  assign w_step     = r_busy && !done;
  assign fail_rdata = r_fail[fail_raddr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_k    <= '0;
      r_len  <= '0;
      for (int n = 0; n < MAX_PAT; n++) r_fail[n] <= '0;
    end else if (start) begin
      r_busy    <= 1'b1;
      r_k       <= c_one_k;
      r_len     <= '0;
      r_fail[0] <= '0;
    end else if (done) begin
      r_busy <= 1'b0;
    end else if (w_step) begin
      if (w_pat[w_kidx] == w_pat[r_len]) begin
        r_fail[w_kidx] <= r_len + c_one_len;
        r_len          <= r_len + c_one_len;
        r_k            <= r_k + c_one_k;
      end else if (r_len != '0) begin
        r_len <= r_fail[r_len - c_one_len];
      end else begin
        r_fail[w_kidx] <= '0;
        r_k            <= r_k + c_one_k;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/kmp_pe.sv
`default_nettype none
// ============================================================
// Module  : kmp_pe
// Desc    : KMP processing element: builds failure table, scans a string window.
//           Option: define KMP_PE_CYCLE_CNT_EN to add the job_cycles counter port.
// Rev     : 1.0
// ============================================================
module kmp_pe
  import sme_pkg::*;
#(
  parameter int STR_ADDR_W = sme_pkg::STR_ADDR_W,
  parameter int PAT_ADDR_W = sme_pkg::PAT_ADDR_W,
  parameter int MAX_PAT    = 2 ** PAT_ADDR_W,
  parameter int CHAR_W     = sme_pkg::CHAR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pat_we,
  input  logic [PAT_ADDR_W-1:0] pat_waddr,
  input  logic [CHAR_W-1:0]     pat_wdata,
  input  logic [PAT_ADDR_W-1:0] pat_last_idx,
  input  logic                  pe_valid,
  input  logic [STR_ADDR_W-1:0] start_idx,
  input  logic [STR_ADDR_W-1:0] end_idx,
  output logic [STR_ADDR_W-1:0] str_raddr,
  input  logic [CHAR_W-1:0]     str_rdata,
  output logic                  match_valid,
  output logic                  match,
  output logic [STR_ADDR_W-1:0] match_idx
`ifdef KMP_PE_CYCLE_CNT_EN
  ,
  output logic [15:0]           job_cycles
`endif
);

  localparam logic [STR_ADDR_W:0]   c_one_i = 1;
  localparam logic [PAT_ADDR_W-1:0] c_one_j = 1;

  pe_state_t             r_state, w_state_nxt;
  logic [CHAR_W-1:0]     r_pat [MAX_PAT];
  logic [MAX_PAT*CHAR_W-1:0] w_pat_flat;
  logic [STR_ADDR_W:0]   r_i, w_i_nxt;
  logic [STR_ADDR_W-1:0] r_end, w_end_nxt;
  logic [PAT_ADDR_W-1:0] r_j, w_j_nxt;
  logic [PAT_ADDR_W-1:0] r_pat_last, w_pat_last_nxt;
  logic                  r_match_valid, w_match_valid_nxt;
  logic                  r_match, w_match_nxt;
  logic [STR_ADDR_W-1:0] r_match_idx, w_match_idx_nxt;
  logic                  w_build_start, w_build_done;
  logic [PAT_ADDR_W-1:0] w_fail_raddr, w_fail_rdata;
  logic                  w_char_eq;

  // Pattern storage deliberately survives reset; the control unit reloads it per pattern.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && pat_we) r_pat[pat_waddr] <= pat_wdata;
  end

  for (genvar g = 0; g < MAX_PAT; g++) begin : g_pat_flat
    assign w_pat_flat[g*CHAR_W +: CHAR_W] = r_pat[g];
  end

  kmp_fail_builder #(
    .PAT_ADDR_W (PAT_ADDR_W),
    .CHAR_W     (CHAR_W),
    .MAX_PAT    (MAX_PAT)
  ) u_fail (
    .clk        (clk),
    .reset      (reset),
    .start      (w_build_start),
    .pat        (w_pat_flat),
    .pat_last   (r_pat_last),
    .done       (w_build_done),
    .fail_raddr (w_fail_raddr),
    .fail_rdata (w_fail_rdata)
  );

  assign w_char_eq    = (str_rdata == r_pat[r_j]);
  assign w_fail_raddr = r_j - c_one_j;

  always_comb begin
    w_state_nxt       = r_state;
    w_i_nxt           = r_i;
    w_j_nxt           = r_j;
    w_end_nxt         = r_end;
    w_pat_last_nxt    = r_pat_last;
    w_match_valid_nxt = r_match_valid;
    w_match_nxt       = r_match;
    w_match_idx_nxt   = r_match_idx;
    w_build_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (pe_valid) begin
          w_i_nxt        = {1'b0, start_idx};
          w_end_nxt      = end_idx;
          w_pat_last_nxt = pat_last_idx;
          w_build_start  = 1'b1;
          w_state_nxt    = ST_BUILD;
        end
      end
      ST_BUILD: begin
        if (!pe_valid) begin
          w_state_nxt = ST_IDLE;
        end else if (w_build_done) begin
          w_j_nxt     = '0;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // i's extra bit makes an index overflow past end_idx=max also compare as i > end
        if (!pe_valid) begin
          w_state_nxt = ST_IDLE;
        end else if (r_i > {1'b0, r_end}) begin
          w_match_valid_nxt = 1'b1;
          w_match_nxt       = 1'b0;
          w_match_idx_nxt   = '0;
          w_state_nxt       = ST_DONE;
        end else if (w_char_eq && r_j == r_pat_last) begin
          w_match_valid_nxt = 1'b1;
          w_match_nxt       = 1'b1;
          w_match_idx_nxt   = r_i[STR_ADDR_W-1:0] - STR_ADDR_W'(r_pat_last);
          w_state_nxt       = ST_DONE;
        end else if (w_char_eq) begin
          w_i_nxt = r_i + c_one_i;
          w_j_nxt = r_j + c_one_j;
        end else if (r_j != '0) begin
          w_j_nxt = w_fail_rdata;
        end else begin
          w_i_nxt = r_i + c_one_i;
        end
      end
      ST_DONE: begin
        if (!pe_valid) begin
          w_match_valid_nxt = 1'b0;
          w_match_nxt       = 1'b0;
          w_match_idx_nxt   = '0;
          w_state_nxt       = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_i           <= '0;
      r_j           <= '0;
      r_end         <= '0;
      r_pat_last    <= '0;
      r_match_valid <= 1'b0;
      r_match       <= 1'b0;
      r_match_idx   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_i           <= w_i_nxt;
      r_j           <= w_j_nxt;
      r_end         <= w_end_nxt;
      r_pat_last    <= w_pat_last_nxt;
      r_match_valid <= w_match_valid_nxt;
      r_match       <= w_match_nxt;
      r_match_idx   <= w_match_idx_nxt;
    end
  end

  assign str_raddr   = (r_state == ST_SCAN) ? r_i[STR_ADDR_W-1:0] : '0;
  assign match_valid = r_match_valid;
  assign match       = r_match;
  assign match_idx   = r_match_idx;

`ifdef KMP_PE_CYCLE_CNT_EN
  logic [15:0] r_job_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_job_cycles <= '0;
    end else if (w_build_start) begin
      r_job_cycles <= '0;
    end else if ((r_state == ST_BUILD || r_state == ST_SCAN) && r_job_cycles != 16'hFFFF) begin
      r_job_cycles <= r_job_cycles + 16'd1;
    end
  end

  assign job_cycles = r_job_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_kmp_pe.sv
`default_nettype none
// ============================================================
// Module  : tb_kmp_pe
// Desc    : Scoreboard bench for kmp_pe.
// Rev     : 1.0
// ============================================================
module tb_kmp_pe;
  import sme_pkg::*;

  localparam int SW = sme_pkg::STR_ADDR_W;
  localparam int PW = sme_pkg::PAT_ADDR_W;
  localparam int CW = sme_pkg::CHAR_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          pat_we;
  logic [PW-1:0] pat_waddr;
  logic [CW-1:0] pat_wdata;
  logic [PW-1:0] pat_last_idx;
  logic          pe_valid;
  logic [SW-1:0] start_idx;
  logic [SW-1:0] end_idx;
  logic [SW-1:0] str_raddr;
  logic [CW-1:0] str_rdata;
  logic          match_valid;
  logic          match;
  logic [SW-1:0] match_idx;
`ifdef KMP_PE_CYCLE_CNT_EN
  logic [15:0]   job_cycles;
`endif

  logic [CW-1:0] str_mem [2**SW];
  logic [CW-1:0] pat_m   [sme_pkg::MAX_PAT];
  int            pat_len_m = 0;

  typedef struct {
    logic          m;
    logic [SW-1:0] idx;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  assign str_rdata = str_mem[str_raddr];

  kmp_pe u_dut (
    .clk          (clk),
    .reset        (reset),
    .pat_we       (pat_we),
    .pat_waddr    (pat_waddr),
    .pat_wdata    (pat_wdata),
    .pat_last_idx (pat_last_idx),
    .pe_valid     (pe_valid),
    .start_idx    (start_idx),
    .end_idx      (end_idx),
    .str_raddr    (str_raddr),
    .str_rdata    (str_rdata),
    .match_valid  (match_valid),
    .match        (match),
    .match_idx    (match_idx)
`ifdef KMP_PE_CYCLE_CNT_EN
    ,
    .job_cycles   (job_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_str(input string s);
    for (int n = 0; n < 2**SW; n++) str_mem[n] = 8'h2E;
    for (int n = 0; n < s.len(); n++) str_mem[n] = s[n];
  endtask

  task automatic load_pat(input string p);
    for (int n = 0; n < p.len(); n++) begin
      pat_we    = 1'b1;
      pat_waddr = PW'(n);
      pat_wdata = p[n];
      pat_m[n]  = p[n];
      @(negedge clk);
    end
    pat_we       = 1'b0;
    pat_last_idx = PW'(p.len() - 1);
    pat_len_m    = p.len() - 1;
  endtask

  function automatic logic [SW:0] ref_find(input int s, input int e);
    logic ok;
    for (int m = s; m + pat_len_m <= e; m++) begin
      ok = 1'b1;
      for (int q = 0; q <= pat_len_m; q++)
        if (str_mem[m+q] != pat_m[q]) ok = 1'b0;
      if (ok) return {1'b1, SW'(m)};
    end
    return '0;
  endfunction

  // Starts and ends at a negedge; probe/poke cycles are counted from pe_valid assertion.
  task automatic run_job(input string tag, input int s, input int e, input logic em,
                         input int eidx, input int probe_cyc, input int poke_cyc);
    exp_t ex, got;
    int   cyc, bound, n;
    ex.m   = em;
    ex.idx = SW'(eidx);
    exp_q.push_back(ex);
    start_idx = SW'(s);
    end_idx   = SW'(e);
    pe_valid  = 1'b1;
    n     = (e >= s) ? (e - s + 1) : 0;
    bound = 2*pat_len_m + 2*n + 3;
    cyc   = 0;
    while (!match_valid && cyc < bound + 4) begin
      @(negedge clk);
      cyc++;
      if (poke_cyc == cyc) begin
        pat_we    = 1'b1;
        pat_waddr = '0;
        pat_wdata = 8'h5A;
      end else begin
        pat_we = 1'b0;
      end
      if (probe_cyc == cyc) check({tag, "_scan_addr"}, 32'(str_raddr), 32'(s));
    end
    pat_we = 1'b0;
    check({tag, "_done_in_time"}, 32'(match_valid && cyc <= bound), 32'd1);
    got = exp_q.pop_front();
    check({tag, "_match"}, 32'(match), 32'(got.m));
    check({tag, "_idx"}, 32'(match_idx), 32'(got.idx));
    repeat (2) @(negedge clk);
    check({tag, "_held"}, {30'd0, match_valid, match}, {30'd0, 1'b1, got.m});
    pe_valid = 1'b0;
    @(negedge clk);
    check({tag, "_clear"}, {25'd0, match_valid, match, match_idx}, 32'd0);
  endtask

  task automatic run_model(input string tag, input int s, input int e);
    logic [SW:0] r;
    r = ref_find(s, e);
    run_job(tag, s, e, r[SW], int'(r[SW-1:0]), 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pe_valid = 1'b0; pat_we = 1'b0; pat_waddr = '0; pat_wdata = '0;
    pat_last_idx = '0; start_idx = '0; end_idx = '0;
    load_str("ABABCABAB");
    repeat (3) @(negedge clk);
    check("rst_outputs", {24'd0, match_valid, match, match_idx}, 32'd0);
    check("rst_raddr", 32'(str_raddr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    load_pat("ABC");
    run_job("abc", 0, 5, 1'b1, 2, 0, 0);

    // pattern write during SCAN must be ignored
    run_job("we_scan", 0, 5, 1'b1, 2, 0, 5);
    run_job("we_after", 0, 5, 1'b1, 2, 0, 0);

    // abort during SCAN, then restart at the very next edge
    start_idx = 0; end_idx = 8; pe_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_scan_addr", 32'(str_raddr), 32'd1);
    check("abort_busy", 32'(match_valid), 32'd0);
    pe_valid = 1'b0;
    @(negedge clk);
    check("abort_clear", {24'd0, match_valid, match, match_idx}, 32'd0);
    check("abort_raddr", 32'(str_raddr), 32'd0);
    run_job("restart", 0, 8, 1'b1, 2, 0, 0);

    // reset asserted during BUILD
    start_idx = 0; end_idx = 5; pe_valid = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1; pe_valid = 1'b0;
    @(negedge clk);
    check("rstb_outputs", {24'd0, match_valid, match, match_idx}, 32'd0);
    check("rstb_state", 32'(u_dut.r_state), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run_job("post_rst", 0, 5, 1'b1, 2, 0, 0);

    load_str("AAAAB");
    load_pat("AAB");
    run_job("aab", 0, 4, 1'b1, 2, 0, 0);
    check("aab_fail", {23'd0, u_dut.u_fail.r_fail[0], u_dut.u_fail.r_fail[1], u_dut.u_fail.r_fail[2]},
          {23'd0, 3'd0, 3'd1, 3'd0});

    load_str("ABABCABAB");
    load_pat("CC");
    run_job("cc", 0, 8, 1'b0, 0, 0, 0);
    run_job("rev_win", 5, 3, 1'b0, 0, 0, 0);

    // write in the same IDLE cycle as pe_valid: "CC" becomes "BC"
    pat_we = 1'b1; pat_waddr = '0; pat_wdata = "B"; pat_m[0] = "B";
    run_job("we_start", 0, 8, 1'b1, 3, 0, 0);

    load_pat("B");
    run_job("one_char", 2, 8, 1'b1, 3, 2, 0);

    load_pat("ABA");
    for (int n = 0; n < 6; n++) begin
      int s, e;
      s = int'($urandom_range(10, 0));
      e = int'($urandom_range(12, 0));
      run_model($sformatf("rnd%0d", n), s, e);
    end

    str_mem[62] = "A"; str_mem[63] = "B";
    load_pat("AB");
    run_job("top_end", 60, 63, 1'b1, 62, 0, 0);
    load_pat("CC");
    run_job("overflow", 50, 63, 1'b0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
